// File: rtl/count_sched.sv
// count_sched: round-robin arbiter sharing one go/done counting engine
// between NUM_REQ requesters, with a watchdog that aborts a transaction
// and resets the engine if done never arrives.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset
//   req_i       per-requester level request, held until ack
//   grant_o     one-hot engine owner, zero when idle
//   ack_o       one-cycle completion pulse to the granted requester
//   err_o       one-cycle pulse with ack when the transaction timed out
//   busy_o      high in every state except IDLE
//   eng_go_o    one-cycle go pulse to the engine
//   eng_done_i  done pulse from the engine
//   eng_rst_o   one-cycle engine reset, on timeout only
//
// state  | meaning
// IDLE   | no owner, waiting for any request
// LAUNCH | winner granted, go pulse to engine, watchdog cleared
// BUSY   | engine running, watchdog counting
// DONE   | ack (and err/eng_rst on timeout) to the owner for one cycle
module count_sched #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 24
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] ack_o,
  output logic               err_o,
  output logic               busy_o,
  output logic               eng_go_o,
  input  logic               eng_done_i,
  output logic               eng_rst_o
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LIM   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]  WD_SAT   = WDW'(TIMEOUT);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               err_q;
  logic               busy_q;
  logic               eng_go_q;
  logic               eng_rst_q;
  logic [WDW-1:0]     wd_q;
  logic [IDXW-1:0]    last_q;

  logic               win_vld_d;
  logic [IDXW-1:0]    win_idx_d;
  logic [NUM_REQ-1:0] win_oh_d;
  logic [IDXW-1:0]    cand;

  // Search offsets last+1 .. last+NUM_REQ (mod NUM_REQ). Walking the offsets
  // from farthest to nearest lets the nearest set request win without a break.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    win_oh_d  = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last_q) + k >= NUM_REQ) ? IDXW'(int'(last_q) + k - NUM_REQ)
                                           : IDXW'(int'(last_q) + k);
      if (req_i[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = cand;
      end
    end
    win_oh_d[win_idx_d] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      eng_go_q  <= 1'b0;
      eng_rst_q <= 1'b0;
      wd_q      <= '0;
      last_q    <= LAST_RST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            state_q  <= LAUNCH;
            grant_q  <= win_oh_d;
            last_q   <= win_idx_d;
            eng_go_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        LAUNCH: begin
          state_q  <= BUSY;
          eng_go_q <= 1'b0;
          wd_q     <= '0;
        end
        BUSY: begin
          // done takes priority over a watchdog expiring in the same cycle
          if (eng_done_i) begin
            state_q <= DONE;
            ack_q   <= grant_q;
          end else if (wd_q == WD_LIM) begin
            state_q   <= DONE;
            ack_q     <= grant_q;
            err_q     <= 1'b1;
            eng_rst_q <= 1'b1;
          end else if (wd_q != WD_SAT) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          grant_q   <= '0;
          ack_q     <= '0;
          err_q     <= 1'b0;
          eng_rst_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign eng_go_o  = eng_go_q;
  assign eng_rst_o = eng_rst_q;

endmodule

// File: doc/count_sched.md
# count_sched

Round-robin scheduler that shares one 16-cycle counting engine (the go/done counter FSM) between NUM_REQ requesters. Accepts level-held requests, grants one requester at a time and issues a single go pulse to the engine. Waits for the engine's done pulse, then acknowledges the granted requester. A watchdog aborts the transaction, resets the engine and flags an error if done never arrives.

## Interface
- NUM_REQ, 4: number of requesters; range 2..8.
- TIMEOUT, 24: maximum BUSY cycles before abort; must be ≥ 18.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- req  in  NUM_REQ  per-requester request, level; held until ack.
- grant  out  NUM_REQ  one-hot owner of the engine; all zero when idle.
- ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse, coincident with ack, when the transaction timed out.
- busy  out  1  high in every state except IDLE.
- eng_go  out  1  go to engine; one-cycle pulse.
- eng_done  in  1  done_sig from engine.
- eng_rst  out  1  engine reset; one-cycle pulse on timeout only.

## Operation
- States: IDLE, LAUNCH, BUSY, DONE. State and all outputs are registered; outputs are Moore-decoded from registered state.
- Reset values: state = IDLE, grant = 0, ack = 0, err = 0, busy = 0, eng_go = 0, eng_rst = 0, watchdog = 0, last = NUM_REQ-1. Requester 0 has highest priority after reset.
- IDLE → LAUNCH: taken when any req bit is high.
  - Winner is the first set req bit searching upward from last+1, wrapping modulo NUM_REQ.
  - grant is loaded with the winner; last is updated to the winner.
- LAUNCH: eng_go = 1 for exactly this cycle; always → BUSY. Watchdog is cleared.
- BUSY:
  - The watchdog increments each cycle. Its width is ceil(log2(TIMEOUT+1)) and it saturates; it never wraps.
  - eng_done = 1 → DONE with timeout flag 0.
  - Otherwise, when the watchdog reaches TIMEOUT-1 → DONE with timeout flag 1.
  - eng_done and timeout in the same cycle: done wins, timeout flag 0.
- DONE: lasts one cycle.
  - ack[winner] = 1.
  - err = eng_rst = timeout flag.
  - grant is still held this cycle and clears on the next.
  - Always → IDLE.
- Request rules:
  - A granted transaction runs to completion even if its req drops.
  - A req still high in the IDLE cycle after ack is a new request. With other requesters pending, round-robin places it last.
- eng_done outside BUSY is ignored; no output changes.
- rst mid-transaction: next cycle all outputs return to reset values and no ack is issued.
  - The engine shares rst, so it also returns to idle.
- Only one grant bit is ever set. ack and grant never disagree.

## Timing
- Uncontended request, req rising before edge 0:
  - LAUNCH in cycle 1 (eng_go = 1).
  - BUSY from cycle 2; engine counts cycles 2–17; eng_done in cycle 18.
  - DONE/ack in cycle 19; IDLE in cycle 20.
  - req→ack latency: 19 cycles.
- Back-to-back: next LAUNCH no earlier than cycle 21. Peak throughput is one transaction per 20 cycles.
- Timeout path: BUSY cycles 2..TIMEOUT+1; DONE in cycle TIMEOUT+2 with ack, err and eng_rst high.
- grant is stable from cycle 1 through the DONE cycle inclusive.

## Test plan
- Reset then req = 0001 → eng_go in cycle 1 only, ack = 0001 in cycle 19, err = 0, busy high in cycles 1–19, grant = 0001 in cycles 1–19.
- req = 1111 held through four transactions, no deassert → grant order 0001, 0010, 0100, 1000, each ack 20 cycles apart.
- req = 0101 with last = 0 → grant 0100 first, then 0001; req[0] dropped mid-BUSY → its transaction still completes with ack.
- Engine model never returns done, TIMEOUT = 24 → ack, err and eng_rst pulse together in cycle 26; IDLE in cycle 27; a later request completes normally.
- Spurious eng_done in IDLE and in LAUNCH → no ack, no state change beyond the normal sequence; eng_done coincident with the watchdog limit → ack with err = 0.
- rst asserted in cycle 10 of a transaction → all outputs zero from cycle 11, no ack; the next request is granted to requester 0 if it is pending.
